store_feeder: RTL and testbench
===============================

// Module: store_feeder
// PURPOSE
//  Producer end of the Store IE/OE handshake. Steps a sequence of values
//  into a Store: presents data, pulses IE, waits for OE high, captures the
//  Store's output, then waits for OE low before sending the next value.
//  Replaces bench-driven stimulus so that Store chains run in hardware.
// PARAMETERS
//  BITS      32  data width, matching the Store's BITS
//  SETUP     2   cycles data is held stable with IE low before the IE pulse (>=1)
//  PULSE     2   cycles IE is held high (>=1)
//  TMO       64  maximum cycles in each wait state before ERR (>=2)
// PORTS
//  CLK     in   1     clock, rising edge
//  INIT    in   1     synchronous active-high reset
//  GO      in   1     start a run; sampled only in IDLE/DONE/ERR
//  FIRST   in   BITS  first value of the run
//  COUNT   in   16    number of values to send; 0 = empty run
//  INP     out  BITS  data to Store INP
//  IE      out  1     input enable to Store IE
//  OUT     in   BITS  Store OUT
//  OE      in   1     Store OE
//  RES     out  BITS  last captured Store output
//  RVAL    out  1     1-cycle pulse: RES updated this cycle
//  BUSY    out  1     run in progress
//  DONE    out  1     sticky: run completed without error
//  ERR     out  1     sticky: handshake timeout
// BEHAVIOUR
//  Reset (INIT=1 at an edge): state=IDLE; INP=0, IE=0, RES=0, RVAL=0, BUSY=0,
//   DONE=0, ERR=0; counters cleared. INIT overrides everything, including mid-run.
//  States: IDLE, SETUP, PULSE, WAIT_HI, WAIT_LO, DONE, ERR.
//  IDLE/DONE/ERR + GO=1: latch FIRST to INP, latch COUNT to remaining count;
//   clear DONE and ERR. COUNT=0 -> DONE next cycle, IE never asserted.
//   Otherwise -> SETUP with BUSY=1.
//  SETUP: IE=0, INP stable for SETUP cycles -> PULSE.
//  PULSE: IE=1 for exactly PULSE cycles. IE falls on PULSE exit -> WAIT_HI.
//  WAIT_HI: on OE=1, RES<=OUT, RVAL=1 for one cycle -> WAIT_LO.
//  WAIT_LO: on OE=0, decrement remaining. If remaining becomes 0 -> DONE
//   (BUSY=0, DONE=1). Otherwise INP<=INP+1 (mod 2^BITS, wraps), -> SETUP.
//  INP changes only on the transition into SETUP. It is stable for all of
//   SETUP, PULSE, WAIT_HI and WAIT_LO.
//  Timeout: a wait counter is cleared on entry to WAIT_HI and to WAIT_LO.
//   When it reaches TMO cycles without the awaited OE level: ERR=1, BUSY=0,
//   IE=0, state=ERR. RES keeps its last value.
//  OE already high on entry to WAIT_HI is accepted on the first WAIT_HI cycle.
//  OE glitches during SETUP/PULSE are ignored.
//  GO while BUSY is ignored (no restart, no error).
//  Latency per value without stalls: SETUP+PULSE+1 cycles to the first
//   OE-sample, plus the Store's response time.
// TESTING
//  1 Reset: INIT high 2 cycles -> all outputs 0, state IDLE; GO held low ->
//    IE stays 0.
//  2 Store (FIRST=0) attached, GO with FIRST=0, COUNT=7 -> 7 IE pulses of
//    PULSE cycles each; RES sequence = Store outputs for inputs 0..6; DONE=1,
//    BUSY=0 after the 7th OE fall.
//  3 COUNT=0 -> DONE=1 one cycle after GO; IE never high; RVAL never pulses.
//  4 BITS=8, FIRST=8'hFE, COUNT=3 -> INP presents FE, FF, 00 (wrap-around).
//  5 OE tied low, COUNT=2 -> ERR=1 exactly TMO cycles after entering WAIT_HI;
//    IE=0, BUSY=0; a following GO clears ERR and restarts from FIRST.
//  6 INIT asserted during PULSE -> next cycle IE=0, state IDLE, all outputs
//    at their reset values; GO during BUSY has no effect on INP or the count.

Source files
------------

// File: rtl/store_feeder.sv
// ---------------------------------------------------------------------------
// store_feeder
//
// Producer end of the Store IE/OE handshake. On GO it steps the values
// FIRST, FIRST+1, ... (COUNT of them) into a Store. For each value it holds
// INP stable with IE low, pulses IE, waits for OE high to capture OUT, then
// waits for OE low before moving on. A bounded wait in either OE state ends
// the run with ERR.
//
// Ports
//   clk    in   1     clock, rising edge
//   init   in   1     synchronous active-high reset, overrides everything
//   go     in   1     start a run (sampled only when not busy)
//   first  in   BITS  first value of the run
//   count  in   16    number of values to send (0 = empty run)
//   inp    out  BITS  data to Store INP
//   ie     out  1     input enable to Store IE
//   out    in   BITS  Store OUT
//   oe     in   1     Store OE
//   res    out  BITS  last captured Store output
//   rval   out  1     one-cycle pulse when res is updated
//   busy   out  1     run in progress
//   done   out  1     sticky: run completed without error
//   err    out  1     sticky: handshake timeout
// ---------------------------------------------------------------------------
module store_feeder #(
    parameter int BITS  = 32,
    parameter int SETUP = 2,
    parameter int PULSE = 2,
    parameter int TMO   = 64
) (
    input  logic            clk,
    input  logic            init,
    input  logic            go,
    input  logic [BITS-1:0] first,
    input  logic [15:0]     count,
    output logic [BITS-1:0] inp,
    output logic            ie,
    input  logic [BITS-1:0] out,
    input  logic            oe,
    output logic [BITS-1:0] res,
    output logic            rval,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETUP   = 3'd1;
    localparam logic [2:0] ST_PULSE   = 3'd2;
    localparam logic [2:0] ST_WAIT_HI = 3'd3;
    localparam logic [2:0] ST_WAIT_LO = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;
    localparam logic [2:0] ST_ERR     = 3'd6;

    // One phase counter serves both SETUP and PULSE, so size it for the longer.
    localparam int PHASE_MAX = (SETUP > PULSE) ? SETUP : PULSE;
    localparam int PW        = $clog2(PHASE_MAX + 1);
    localparam int WW        = $clog2(TMO + 1);

    logic [2:0]      state_reg,     state_next;
    logic [BITS-1:0] inp_reg,       inp_next;
    logic            ie_reg,        ie_next;
    logic [BITS-1:0] res_reg,       res_next;
    logic            rval_reg,      rval_next;
    logic            busy_reg,      busy_next;
    logic            done_reg,      done_next;
    logic            err_reg,       err_next;
    logic [15:0]     remaining_reg, remaining_next;
    logic [PW-1:0]   phase_reg,     phase_next;
    logic [WW-1:0]   wait_reg,      wait_next;

    // Both wait states share the same timeout exit.
    logic            wait_expired;
    assign wait_expired = (wait_reg == WW'(TMO - 1));

    always_comb begin
        state_next     = state_reg;
        inp_next       = inp_reg;
        ie_next        = ie_reg;
        res_next       = res_reg;
        rval_next      = 1'b0;
        busy_next      = busy_reg;
        done_next      = done_reg;
        err_next       = err_reg;
        remaining_next = remaining_reg;
        phase_next     = phase_reg;
        wait_next      = wait_reg;

        case (state_reg)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (go) begin
                    inp_next       = first;
                    remaining_next = count;
                    done_next      = 1'b0;
                    err_next       = 1'b0;
                    phase_next     = '0;
                    if (count == 16'd0) begin
                        state_next = ST_DONE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = ST_SETUP;
                        busy_next  = 1'b1;
                    end
                end
            end

            ST_SETUP: begin
                if (phase_reg == PW'(SETUP - 1)) begin
                    state_next = ST_PULSE;
                    ie_next    = 1'b1;
                    phase_next = '0;
                end else begin
                    phase_next = phase_reg + PW'(1);
                end
            end

            ST_PULSE: begin
                if (phase_reg == PW'(PULSE - 1)) begin
                    state_next = ST_WAIT_HI;
                    ie_next    = 1'b0;
                    wait_next  = '0;
                end else begin
                    phase_next = phase_reg + PW'(1);
                end
            end

            ST_WAIT_HI: begin
                // OE may already be high here; it is accepted on the first cycle.
                if (oe) begin
                    res_next   = out;
                    rval_next  = 1'b1;
                    state_next = ST_WAIT_LO;
                    wait_next  = '0;
                end else if (wait_expired) begin
                    state_next = ST_ERR;
                    err_next   = 1'b1;
                    busy_next  = 1'b0;
                    ie_next    = 1'b0;
                end else begin
                    wait_next = wait_reg + WW'(1);
                end
            end

            ST_WAIT_LO: begin
                if (!oe) begin
                    remaining_next = remaining_reg - 16'd1;
                    if (remaining_reg == 16'd1) begin
                        state_next = ST_DONE;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                    end else begin
                        // INP only ever moves on the way back into SETUP.
                        inp_next   = inp_reg + BITS'(1);
                        state_next = ST_SETUP;
                        phase_next = '0;
                    end
                end else if (wait_expired) begin
                    state_next = ST_ERR;
                    err_next   = 1'b1;
                    busy_next  = 1'b0;
                    ie_next    = 1'b0;
                end else begin
                    wait_next = wait_reg + WW'(1);
                end
            end

            default: begin
                state_next = ST_IDLE;
                ie_next    = 1'b0;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (init) begin
            state_reg     <= ST_IDLE;
            inp_reg       <= '0;
            ie_reg        <= 1'b0;
            res_reg       <= '0;
            rval_reg      <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            remaining_reg <= '0;
            phase_reg     <= '0;
            wait_reg      <= '0;
        end else begin
            state_reg     <= state_next;
            inp_reg       <= inp_next;
            ie_reg        <= ie_next;
            res_reg       <= res_next;
            rval_reg      <= rval_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
            remaining_reg <= remaining_next;
            phase_reg     <= phase_next;
            wait_reg      <= wait_next;
        end
    end

    assign inp  = inp_reg;
    assign ie   = ie_reg;
    assign res  = res_reg;
    assign rval = rval_reg;
    assign busy = busy_reg;
    assign done = done_reg;
    assign err  = err_reg;

endmodule

// File: tb/tb_store_feeder.sv
// ---------------------------------------------------------------------------
// tb_store_feeder
//
// Drives store_feeder (BITS=8) against a behavioural Store responder that
// answers each IE rise with OE high and OUT = xform(INP) after a chosen
// delay. Expected INP/RES sequences come from plain arithmetic on FIRST and
// COUNT. Table vectors, hand-written timing sequences and random runs.
// ---------------------------------------------------------------------------
module tb_store_feeder;

    localparam int BITS_P  = 8;
    localparam int SETUP_P = 2;
    localparam int PULSE_P = 2;
    localparam int TMO_P   = 16;

    logic        clk = 1'b0;
    logic        init = 1'b1;
    logic        go = 1'b0;
    logic [7:0]  first = 8'd0;
    logic [15:0] count = 16'd0;
    logic [7:0]  inp;
    logic        ie;
    logic [7:0]  out = 8'd0;
    logic        oe = 1'b0;
    logic [7:0]  res;
    logic        rval;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    store_feeder #(
        .BITS (BITS_P),
        .SETUP(SETUP_P),
        .PULSE(PULSE_P),
        .TMO  (TMO_P)
    ) dut (
        .clk  (clk),
        .init (init),
        .go   (go),
        .first(first),
        .count(count),
        .inp  (inp),
        .ie   (ie),
        .out  (out),
        .oe   (oe),
        .res  (res),
        .rval (rval),
        .busy (busy),
        .done (done),
        .err  (err)
    );

    always #5 clk = ~clk;

    // Store behaviour: OUT is a fixed function of the value presented.
    function automatic logic [7:0] xform(input logic [7:0] x);
        logic [7:0] t;
        t = x * 8'd3;
        return t ^ 8'hA5;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end else begin
            $display("ok   %s value=%0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Responder / monitor state (mode 0 normal, 1 OE tied low, 2 OE stuck high)
    int         resp_mode = 0;
    int         hi_delay = 1;
    int         lo_delay = 3;
    int         phase = 0;
    int         hi_cnt = 0;
    int         lo_cnt = 0;
    logic [7:0] latched = 8'd0;
    logic       ie_prev = 1'b0;
    int         pw = 0;
    bit         pw_check_en = 1'b1;
    logic [7:0] seen_inp[$];
    logic [7:0] seen_res[$];

    // Runs 2 time units after each edge so the main process (at +1) never races it.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (ie === 1'b1 && ie_prev !== 1'b1) seen_inp.push_back(inp);
            if (ie === 1'b1) begin
                pw++;
            end else if (ie_prev === 1'b1) begin
                if (pw_check_en) check("ie_width", pw, PULSE_P);
                pw = 0;
            end
            if (rval === 1'b1) seen_res.push_back(res);

            if (resp_mode == 1) begin
                oe = 1'b0;
            end else begin
                if (ie === 1'b1 && ie_prev !== 1'b1 && phase == 0) begin
                    latched = inp;
                    hi_cnt  = hi_delay;
                    phase   = 1;
                end
                if (phase == 1) begin
                    if (hi_cnt == 0) begin
                        oe     = 1'b1;
                        out    = xform(latched);
                        lo_cnt = lo_delay;
                        phase  = 2;
                    end else begin
                        hi_cnt--;
                    end
                end else if (phase == 2 && resp_mode != 2) begin
                    if (lo_cnt == 0) begin
                        oe    = 1'b0;
                        phase = 0;
                    end else begin
                        lo_cnt--;
                    end
                end
            end
            ie_prev = ie;
        end
    end

    task automatic resp_setup(input int mode, input int h, input int l);
        resp_mode = mode;
        hi_delay  = h;
        lo_delay  = l;
        phase     = 0;
        oe        = 1'b0;
        seen_inp.delete();
        seen_res.delete();
    endtask

    task automatic wait_end(input string name);
        int n;
        n = 0;
        while (!(done === 1'b1 || err === 1'b1) && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=still_busy required=done_or_err", name);
        end
        tick();
        tick();
    endtask

    task automatic start_run(input logic [7:0] f, input logic [15:0] c);
        first = f;
        count = c;
        go    = 1'b1;
        tick();
        go    = 1'b0;
    endtask

    // Compare observed INP presentations and captured RES against the model.
    task automatic compare_run(input string name, input logic [7:0] f, input int n_inp, input int n_res);
        logic [7:0] e;
        check({name, "_pulses"}, seen_inp.size(), n_inp);
        check({name, "_rvals"}, seen_res.size(), n_res);
        for (int i = 0; i < n_inp && i < seen_inp.size(); i++) begin
            e = f + 8'(i);
            check($sformatf("%s_inp%0d", name, i), seen_inp[i], e);
        end
        for (int i = 0; i < n_res && i < seen_res.size(); i++) begin
            e = f + 8'(i);
            check($sformatf("%s_res%0d", name, i), seen_res[i], xform(e));
        end
        if (n_res > 0) begin
            e = f + 8'(n_res - 1);
            check({name, "_res_final"}, res, xform(e));
        end
    endtask

    typedef struct {
        logic [7:0]  first;
        logic [15:0] count;
        int          mode;
        int          h;
        int          l;
        bit          exp_done;
        bit          exp_err;
        int          exp_pulses;
        int          exp_nres;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int         n;
        int         ie_seen;
        logic [7:0] f;
        logic [15:0] c;
        logic [7:0] res_before;

        vecs[0] = '{8'h00, 16'd7, 0, 1, 3, 1'b1, 1'b0, 7, 7};
        vecs[1] = '{8'hFE, 16'd3, 0, 2, 4, 1'b1, 1'b0, 3, 3};
        vecs[2] = '{8'h05, 16'd0, 0, 1, 3, 1'b1, 1'b0, 0, 0};
        vecs[3] = '{8'h09, 16'd2, 1, 0, 3, 1'b0, 1'b1, 1, 0};
        vecs[4] = '{8'h80, 16'd1, 2, 0, 3, 1'b0, 1'b1, 1, 1};
        vecs[5] = '{8'h33, 16'd4, 0, 5, 6, 1'b1, 1'b0, 4, 4};

        // Reset: two cycles of init, everything zero, IE idle with GO low.
        init = 1'b1;
        tick();
        tick();
        check("rst_inp", inp, 0);
        check("rst_ie", ie, 0);
        check("rst_res", res, 0);
        check("rst_rval", rval, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        init = 1'b0;
        ie_seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ie !== 1'b0) ie_seen++;
        end
        check("idle_ie_quiet", ie_seen, 0);

        // Table-driven runs.
        for (int v = 0; v < 6; v++) begin
            resp_setup(vecs[v].mode, vecs[v].h, vecs[v].l);
            start_run(vecs[v].first, vecs[v].count);
            wait_end($sformatf("vec%0d", v));
            check($sformatf("vec%0d_done", v), done, vecs[v].exp_done);
            check($sformatf("vec%0d_err", v), err, vecs[v].exp_err);
            check($sformatf("vec%0d_busy", v), busy, 0);
            check($sformatf("vec%0d_ie", v), ie, 0);
            compare_run($sformatf("vec%0d", v), vecs[v].first, vecs[v].exp_pulses, vecs[v].exp_nres);
        end

        // COUNT=0: done exactly one cycle after GO, no IE.
        resp_setup(0, 1, 3);
        start_run(8'h44, 16'd0);
        check("empty_done_1cyc", done, 1);
        check("empty_busy", busy, 0);
        check("empty_ie", ie, 0);
        check("empty_inp_latched", inp, 8'h44);
        tick();
        tick();

        // Timeout: OE tied low, ERR exactly TMO cycles after entering WAIT_HI.
        res_before = res;
        resp_setup(1, 0, 3);
        start_run(8'h03, 16'd2);
        n = 0;
        while (err !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("tmo_cycles", n, SETUP_P + PULSE_P + TMO_P);
        check("tmo_ie", ie, 0);
        check("tmo_busy", busy, 0);
        check("tmo_res_kept", res, res_before);
        // A following GO clears ERR and restarts from FIRST.
        resp_setup(0, 1, 3);
        start_run(8'h03, 16'd2);
        check("restart_err_clr", err, 0);
        check("restart_inp", inp, 8'h03);
        check("restart_busy", busy, 1);
        wait_end("restart");
        check("restart_done", done, 1);
        compare_run("restart", 8'h03, 2, 2);

        // INIT during PULSE returns everything to reset values.
        resp_setup(0, 1, 3);
        start_run(8'h20, 16'd4);
        n = 0;
        while (ie !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("midrun_reached_pulse", ie, 1);
        pw_check_en = 1'b0;
        init = 1'b1;
        tick();
        check("midrun_ie", ie, 0);
        check("midrun_inp", inp, 0);
        check("midrun_res", res, 0);
        check("midrun_busy", busy, 0);
        check("midrun_done", done, 0);
        check("midrun_err", err, 0);
        init = 1'b0;
        tick();
        tick();
        pw_check_en = 1'b1;

        // GO while busy: no effect on INP or the count.
        resp_setup(0, 2, 4);
        start_run(8'h40, 16'd3);
        first = 8'h99;
        count = 16'd9;
        go    = 1'b1;
        tick();
        tick();
        tick();
        go = 1'b0;
        check("busy_go_inp", inp, 8'h40);
        wait_end("busy_go");
        check("busy_go_done", done, 1);
        compare_run("busy_go", 8'h40, 3, 3);

        // Latency to first OE sample with OE already high at WAIT_HI entry.
        resp_setup(0, 0, 3);
        start_run(8'h10, 16'd1);
        n = 0;
        while (rval !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("latency_rval", n, SETUP_P + PULSE_P + 1);
        check("latency_res", res, xform(8'h10));
        wait_end("latency");
        check("latency_done", done, 1);

        // Random runs against the arithmetic model.
        for (int r = 0; r < 20; r++) begin
            f = 8'($urandom_range(0, 255));
            c = 16'($urandom_range(1, 8));
            resp_setup(0, int'($urandom_range(0, 5)), int'($urandom_range(3, 6)));
            start_run(f, c);
            wait_end($sformatf("rnd%0d", r));
            check($sformatf("rnd%0d_done", r), done, 1);
            check($sformatf("rnd%0d_err", r), err, 0);
            compare_run($sformatf("rnd%0d", r), f, int'(c), int'(c));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
